// File: rtl/mutex_reader_pkg.sv
// Shared types and default widths for the mutex buffer frame reader.
// The optional stale-frame detection is enabled by defining MUTEX_READER_STALE_EN.
package mutex_reader_pkg;

   localparam int unsigned DEF_ADDR_WIDTH     = 32;
   localparam int unsigned DEF_TS_WIDTH       = 64;
   localparam int unsigned DEF_BUFF_IDX_WIDTH = 2;
   localparam int unsigned DEF_IMG_HBITS      = 12;
   localparam int unsigned DEF_LEN_WIDTH      = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOCK  = 3'd1,
      ST_LATCH = 3'd2,
      ST_ISSUE = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

endpackage

// File: rtl/mutex_reader_addr_gen.sv
// Line address generator: loads the locked buffer base, steps by the line stride
// on every accepted command and flags the final line of the frame.
module mutex_reader_addr_gen
   import mutex_reader_pkg::*;
#(
   parameter int unsigned C_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned C_IMG_HBITS  = DEF_IMG_HBITS
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_load,
   input  logic [C_ADDR_WIDTH-1:0] i_base,
   input  logic [C_ADDR_WIDTH-1:0] i_stride,
   input  logic [C_IMG_HBITS-1:0]  i_height,
   input  logic                    i_accept,
   output logic [C_ADDR_WIDTH-1:0] o_addr,
   output logic                    o_last
);

   logic [C_IMG_HBITS-1:0] r_issued;

   // last is precomputed one accept ahead so it is valid together with the address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_addr   <= '0;
         o_last   <= 1'b0;
         r_issued <= '0;
      end else if (i_load) begin
         o_addr   <= i_base;
         o_last   <= (i_height == C_IMG_HBITS'(1));
         r_issued <= '0;
      end else if (i_accept) begin
         o_addr   <= o_addr + i_stride;
         o_last   <= ((r_issued + C_IMG_HBITS'(2)) == i_height);
         r_issued <= r_issued + C_IMG_HBITS'(1);
      end
   end

endmodule

// File: rtl/mutex_buffer_frame_reader.sv
// Reader client of the mutex buffer manager: locks the latest buffer and issues one
// read command per line. Define MUTEX_READER_STALE_EN to flag frames with a repeated timestamp.
module mutex_buffer_frame_reader
   import mutex_reader_pkg::*;
#(
   parameter int unsigned C_ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned C_TS_WIDTH       = DEF_TS_WIDTH,
   parameter int unsigned C_BUFF_IDX_WIDTH = DEF_BUFF_IDX_WIDTH,
   parameter int unsigned C_IMG_HBITS      = DEF_IMG_HBITS,
   parameter int unsigned C_LEN_WIDTH      = DEF_LEN_WIDTH
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        fsync,
   input  logic [C_IMG_HBITS-1:0]      img_height,
   input  logic [C_LEN_WIDTH-1:0]      line_bytes,
   input  logic [C_ADDR_WIDTH-1:0]     line_stride,
   output logic                        r_sof,
   input  logic [C_ADDR_WIDTH-1:0]     r_addr,
   input  logic [C_BUFF_IDX_WIDTH-1:0] r_idx,
   input  logic [C_TS_WIDTH-1:0]       r_ts,
   output logic                        cmd_valid,
   input  logic                        cmd_ready,
   output logic [C_ADDR_WIDTH-1:0]     cmd_addr,
   output logic [C_LEN_WIDTH-1:0]      cmd_len,
   output logic                        cmd_last,
   input  logic                        line_done,
   output logic                        busy,
   output logic                        frame_done,
   output logic [C_BUFF_IDX_WIDTH-1:0] frame_idx,
   output logic [C_TS_WIDTH-1:0]       frame_ts,
   output logic                        overrun,
   output logic                        stale
);

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [C_IMG_HBITS-1:0]  r_height;
   logic [C_ADDR_WIDTH-1:0] r_stride;
   logic [C_IMG_HBITS-1:0]  r_done_cnt;
   logic [C_IMG_HBITS-1:0]  w_done_nxt;
   logic                    w_accept;
   logic                    w_start;
   logic                    w_load;
   logic                    w_finish;
   logic                    w_ovr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // a frame_done cycle still counts as busy for fsync so back-to-back requests are flagged
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_finish    = 1'b0;
      w_accept    = cmd_valid & cmd_ready;
      w_done_nxt  = r_done_cnt + C_IMG_HBITS'(line_done);
      w_ovr       = fsync & ((r_state != ST_IDLE) | frame_done);
      case (r_state)
         ST_IDLE: begin
            if (fsync && !frame_done && (img_height != '0)) begin
               w_start     = 1'b1;
               w_state_nxt = ST_LOCK;
            end
         end
         ST_LOCK:  w_state_nxt = ST_LATCH;
         ST_LATCH: begin
            w_load      = 1'b1;
            w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (w_accept && cmd_last) begin
               if (w_done_nxt == r_height) begin
                  w_finish    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (w_done_nxt == r_height) begin
               w_finish    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sof      <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_len    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_idx  <= '0;
         frame_ts   <= '0;
         overrun    <= 1'b0;
         r_height   <= '0;
         r_stride   <= '0;
         r_done_cnt <= '0;
      end else begin
         r_sof      <= w_start;
         cmd_valid  <= (w_state_nxt == ST_ISSUE);
         busy       <= (w_state_nxt != ST_IDLE);
         frame_done <= w_finish;
         overrun    <= overrun | w_ovr;
         if (w_start) begin
            r_height   <= img_height;
            r_stride   <= line_stride;
            cmd_len    <= line_bytes;
            r_done_cnt <= '0;
         end
         if (w_load) begin
            frame_idx <= r_idx;
            frame_ts  <= r_ts;
         end
         if (((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) && line_done)
            r_done_cnt <= w_done_nxt;
      end
   end

`ifdef MUTEX_READER_STALE_EN
   // frame_ts still holds the previous frame's stamp during LATCH
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       stale <= 1'b0;
      else if (w_load) stale <= (r_ts == frame_ts);
   end
`else
   assign stale = 1'b0;
`endif

   mutex_reader_addr_gen #(
      .C_ADDR_WIDTH (C_ADDR_WIDTH),
      .C_IMG_HBITS  (C_IMG_HBITS)
   ) u_addr_gen (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_base   (r_addr),
      .i_stride (r_stride),
      .i_height (r_height),
      .i_accept (w_accept),
      .o_addr   (cmd_addr),
      .o_last   (cmd_last)
   );

endmodule

// File: tb/tb_mutex_buffer_frame_reader.sv
// Scoreboard bench for mutex_buffer_frame_reader: expected commands and frame records
// are queued at frame start and popped by a monitor on handshakes and frame_done.
module tb_mutex_buffer_frame_reader;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] len;
      logic        last;
   } cmd_t;

   typedef struct {
      logic [1:0]  idx;
      logic [63:0] ts;
      logic        stale;
   } frm_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        fsync;
   logic [11:0] img_height;
   logic [15:0] line_bytes;
   logic [31:0] line_stride;
   logic        r_sof;
   logic [31:0] r_addr = '0;
   logic [1:0]  r_idx = '0;
   logic [63:0] r_ts = '0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_len;
   logic        cmd_last;
   logic        line_done = 1'b0;
   logic        busy;
   logic        frame_done;
   logic [1:0]  frame_idx;
   logic [63:0] frame_ts;
   logic        overrun;
   logic        stale;

   int n_cmp = 0;
   int n_err = 0;

   cmd_t exp_cmd[$];
   frm_t exp_frm[$];
   logic [63:0] prev_ts = '0;
   int exp_sof = 0;
   int exp_frames = 0;
   int sof_cnt = 0;
   int done_cnt = 0;
   int pending = 0;
   int acc_total = 0;
   int acc_base = 0;
   int ready_mode = 0;
   int stall_cnt = 0;

   logic [31:0] mgr_addr = '0;
   logic [1:0]  mgr_idx = '0;
   logic [63:0] mgr_ts = '0;

   logic        stall_prev = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [15:0] prev_len = '0;
   logic        prev_last = 1'b0;

   always #5 clk = ~clk;

   mutex_buffer_frame_reader dut (
      .clk         (clk),
      .reset       (reset),
      .fsync       (fsync),
      .img_height  (img_height),
      .line_bytes  (line_bytes),
      .line_stride (line_stride),
      .r_sof       (r_sof),
      .r_addr      (r_addr),
      .r_idx       (r_idx),
      .r_ts        (r_ts),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .cmd_last    (cmd_last),
      .line_done   (line_done),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_idx   (frame_idx),
      .frame_ts    (frame_ts),
      .overrun     (overrun),
      .stale       (stale)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Manager model: junk on the buffer bus after fsync, real lock data the cycle after r_sof
   always @(negedge clk) begin
      if (!reset && r_sof) begin
         @(posedge clk);
         #1;
         r_addr = mgr_addr;
         r_idx  = mgr_idx;
         r_ts   = mgr_ts;
      end else if (fsync) begin
         @(posedge clk);
         #1;
         r_addr = $urandom;
         r_idx  = 2'($urandom);
         r_ts   = {$urandom, $urandom};
      end
   end

   // Downstream model: ready pattern and line completions for accepted lines
   always @(posedge clk) begin
      #1;
      if ((acc_total - acc_base) == 0) stall_cnt = 0;
      case (ready_mode)
         1: cmd_ready = ($urandom_range(0, 3) != 0);
         2: begin
            if ((acc_total - acc_base) == 1 && stall_cnt < 4) begin
               cmd_ready = 1'b0;
               stall_cnt++;
            end else begin
               cmd_ready = 1'b1;
            end
         end
         default: cmd_ready = 1'b1;
      endcase
      line_done = !reset && (pending > 0) && ($urandom_range(0, 2) != 0);
   end

   // Monitor: command hold, command contents, frame completion
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
         pending    = 0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 64'(cmd_valid), 64'(1));
            check("hold_addr", 64'(cmd_addr), 64'(prev_addr));
            check("hold_len", 64'(cmd_len), 64'(prev_len));
            check("hold_last", 64'(cmd_last), 64'(prev_last));
         end
         if (cmd_valid && cmd_ready) begin
            if (exp_cmd.size() == 0) begin
               check("cmd_unexpected", 64'(1), 64'(0));
            end else begin
               cmd_t e;
               e = exp_cmd.pop_front();
               check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
               check("cmd_len", 64'(cmd_len), 64'(e.len));
               check("cmd_last", 64'(cmd_last), 64'(e.last));
            end
            acc_total++;
            pending++;
         end
         if (line_done) pending--;
         stall_prev = cmd_valid && !cmd_ready;
         prev_addr  = cmd_addr;
         prev_len   = cmd_len;
         prev_last  = cmd_last;
         if (r_sof) sof_cnt++;
         if (frame_done) begin
            done_cnt++;
            check("done_busy", 64'(busy), 64'(0));
            check("done_cmds_left", 64'(exp_cmd.size()), 64'(0));
            if (exp_frm.size() == 0) begin
               check("done_unexpected", 64'(1), 64'(0));
            end else begin
               frm_t f;
               f = exp_frm.pop_front();
               check("frame_idx", 64'(frame_idx), 64'(f.idx));
               check("frame_ts", frame_ts, f.ts);
               check("stale", 64'(stale), 64'(f.stale));
            end
         end
      end
   end

   // Queue the expected frame, pulse fsync, check lock/latch/issue latency
   task automatic start_frame(input int h, input logic [15:0] bytes, input logic [31:0] stride,
                              input logic [31:0] base, input logic [1:0] idx, input logic [63:0] ts);
      frm_t f;
      mgr_addr = base;
      mgr_idx  = idx;
      mgr_ts   = ts;
      for (int i = 0; i < h; i++) begin
         cmd_t c;
         c.addr = base + 32'(i) * stride;
         c.len  = bytes;
         c.last = (i == h - 1);
         exp_cmd.push_back(c);
      end
      f.idx = idx;
      f.ts  = ts;
`ifdef MUTEX_READER_STALE_EN
      f.stale = (ts == prev_ts);
`else
      f.stale = 1'b0;
`endif
      exp_frm.push_back(f);
      prev_ts = ts;
      exp_sof++;
      exp_frames++;
      acc_base    = acc_total;
      fsync       = 1'b1;
      img_height  = 12'(h);
      line_bytes  = bytes;
      line_stride = stride;
      tick();
      fsync       = 1'b0;
      img_height  = 12'($urandom);
      line_bytes  = 16'($urandom);
      line_stride = $urandom;
      check("sof_n1", 64'(r_sof), 64'(1));
      check("busy_n1", 64'(busy), 64'(1));
      check("valid_n1", 64'(cmd_valid), 64'(0));
      tick();
      check("sof_n2", 64'(r_sof), 64'(0));
      check("valid_n2", 64'(cmd_valid), 64'(0));
      tick();
      check("valid_n3", 64'(cmd_valid), 64'(1));
   endtask

   task automatic wait_done();
      for (int i = 0; i < 2000; i++) begin
         if (done_cnt >= exp_frames) break;
         @(posedge clk);
      end
      n_cmp++;
      if (done_cnt < exp_frames) begin
         n_err++;
         $display("FAIL frame_timeout: got %0d frames expected %0d", done_cnt, exp_frames);
      end
      tick();
      tick();
   endtask

   initial begin
      reset       = 1'b1;
      fsync       = 1'b0;
      img_height  = '0;
      line_bytes  = '0;
      line_stride = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sof", 64'(r_sof), 64'(0));
      check("rst_valid", 64'(cmd_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(frame_done), 64'(0));
      check("rst_overrun", 64'(overrun), 64'(0));
      check("rst_stale", 64'(stale), 64'(0));
      check("rst_addr", 64'(cmd_addr), 64'(0));
      check("rst_ts", frame_ts, 64'(0));
      reset = 1'b0;
      tick();
      tick();

      // basic three-line frame, ready always high
      ready_mode = 0;
      start_frame(3, 16'h0800, 32'h0000_1000, 32'h1000_0000, 2'd1, 64'h1234);
      wait_done();
      check("basic_busy", 64'(busy), 64'(0));

      // line 1 held off for four cycles
      ready_mode = 2;
      start_frame(3, 16'h0400, 32'h0000_0800, 32'h2000_0000, 2'd2, 64'h2345);
      wait_done();

      // fsync while busy is ignored and flagged
      ready_mode = 1;
      check("ovr_clear", 64'(overrun), 64'(0));
      start_frame(6, 16'h0100, 32'h0000_0200, 32'h3000_0000, 2'd3, 64'h3456);
      fsync      = 1'b1;
      img_height = 12'd5;
      tick();
      fsync = 1'b0;
      tick();
      check("ovr_set", 64'(overrun), 64'(1));
      wait_done();
      check("ovr_no_sof", 64'(sof_cnt), 64'(exp_sof));
      start_frame(2, 16'h0010, 32'h0000_0040, 32'h3100_0000, 2'd0, 64'h4567);
      wait_done();
      check("ovr_sticky", 64'(overrun), 64'(1));

      // zero-height request is ignored
      fsync      = 1'b1;
      img_height = '0;
      tick();
      fsync = 1'b0;
      repeat (4) tick();
      check("h0_no_sof", 64'(sof_cnt), 64'(exp_sof));
      check("h0_busy", 64'(busy), 64'(0));
      check("h0_valid", 64'(cmd_valid), 64'(0));

      // address wraps past the top of the address space
      start_frame(3, 16'h0800, 32'h0000_1000, 32'hFFFF_F000, 2'd1, 64'h5678);
      wait_done();

      // reset in the middle of command issue
      start_frame(8, 16'h0200, 32'h0000_0400, 32'h4000_0000, 2'd2, 64'h6789);
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid", 64'(cmd_valid), 64'(0));
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_overrun", 64'(overrun), 64'(0));
      exp_cmd.delete();
      exp_frm.delete();
      exp_frames--;
      prev_ts = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      start_frame(4, 16'h0300, 32'h0000_0600, 32'h5000_0000, 2'd3, 64'h789A);
      wait_done();

      // repeated timestamp marks a stale frame when detection is built in
      start_frame(2, 16'h0020, 32'h0000_0100, 32'h6000_0000, 2'd0, 64'h55);
      wait_done();
      start_frame(2, 16'h0020, 32'h0000_0100, 32'h6000_0000, 2'd0, 64'h55);
      wait_done();
      start_frame(2, 16'h0020, 32'h0000_0100, 32'h6000_0000, 2'd1, 64'h56);
      wait_done();

      // randomized frames
      for (int k = 0; k < 10; k++) begin
         ready_mode = int'($urandom_range(0, 1));
         start_frame(int'($urandom_range(1, 7)), 16'($urandom), $urandom, $urandom,
                     2'($urandom), {$urandom, $urandom});
         wait_done();
      end

      check("end_cmd_q", 64'(exp_cmd.size()), 64'(0));
      check("end_frm_q", 64'(exp_frm.size()), 64'(0));
      check("end_sof", 64'(sof_cnt), 64'(exp_sof));
      check("end_frames", 64'(done_cnt), 64'(exp_frames));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
